lock_controller: RTL and testbench

- Downstream consumer of the keyList stage in the FPGA keylock.
- Takes the 32-bit `typed` history (four 8-bit key codes) and a submit strobe, and compares the entry against a stored 4-key code.
- Drives the unlock output, counts failed attempts and enforces a timed lockout.
- While unlocked, allows the stored code to be re-programmed from `typed`.

---
 rtl/keylock_pkg.sv | 29 ++
 rtl/keylock_timer.sv | 30 +++
 rtl/lock_controller.sv | 157 +++++++++++++++
 tb/tb_lock_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/keylock_pkg.sv
// Shared definitions for the keylock datapath: key geometry, controller states
// and a helper that validates a four-key entry.
package keylock_pkg;

    localparam int KEY_W     = 8;
    localparam int CODE_KEYS = 4;
    localparam int CODE_W    = KEY_W * CODE_KEYS;
    localparam logic [KEY_W-1:0] EMPTY_KEY = 8'h00;

    typedef enum logic [1:0] {
        LOCKED,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } lock_state_t;

    // An entry is only storable as a code when no slot is still empty.
    function automatic logic all_keys_valid(input logic [CODE_W-1:0] entry);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < CODE_KEYS; k++) begin
            if (entry[k*KEY_W +: KEY_W] == EMPTY_KEY) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/keylock_timer.sv
// Loadable down-counter shared by the lockout and auto-relock intervals.
// Saturates at zero; load takes priority over counting.
module keylock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign one  = (count == W'(1));

endmodule

// File: rtl/lock_controller.sv
// Keylock controller: checks submitted entries against the stored code, tracks
// failures with a timed lockout, and allows re-programming while unlocked.
module lock_controller
    import keylock_pkg::*;
#(
    parameter logic [31:0] DEFAULT_CODE   = 32'h01020304,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter int          UNLOCK_TIMEOUT = 5000
) (
    input  logic              hwclk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] typed,
    input  logic              submit,
    input  logic              set_mode,
    input  logic              lock_req,
    output logic              unlocked,
    output logic              alarm,
    output logic              clear_list,
    output logic              code_saved,
    output logic              code_err,
    output logic [3:0]        attempts_left
);

    localparam int TIMER_MAX = (LOCKOUT_CYCLES > UNLOCK_TIMEOUT) ? LOCKOUT_CYCLES : UNLOCK_TIMEOUT;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_TIMEOUT);
    localparam logic [3:0]         MAX_FAIL     = 4'(MAX_ATTEMPTS);

    lock_state_t       state, state_next;
    logic [CODE_W-1:0] code, code_next;
    logic [CODE_W-1:0] cand_reg, cand_next;
    logic [3:0]        fail_cnt, fail_next;
    logic              tmr_load, tmr_en, tmr_zero, tmr_one;
    logic [TIMER_W-1:0] tmr_load_val;
    logic              clear_d, saved_d, err_d;

    keylock_timer #(.W(TIMER_W)) u_timer (
        .clk      (hwclk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            code     <= DEFAULT_CODE;
            cand_reg <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= state_next;
            code     <= code_next;
            cand_reg <= cand_next;
            fail_cnt <= fail_next;
        end
    end

    always_comb begin
        state_next   = state;
        code_next    = code;
        cand_next    = cand_reg;
        fail_next    = fail_cnt;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        clear_d      = 1'b0;
        saved_d      = 1'b0;
        err_d        = 1'b0;

        case (state)
            LOCKED: begin
                if (submit) begin
                    cand_next  = typed;
                    state_next = CHECK;
                end
            end

            CHECK: begin
                clear_d = 1'b1;
                if (cand_reg == code) begin
                    state_next   = UNLOCKED;
                    fail_next    = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = UNLOCK_LOAD;
                end else if ((fail_cnt + 4'd1) == MAX_FAIL) begin
                    state_next   = LOCKOUT;
                    fail_next    = MAX_FAIL;
                    tmr_load     = 1'b1;
                    tmr_load_val = LOCKOUT_LOAD;
                end else begin
                    state_next = LOCKED;
                    fail_next  = fail_cnt + 4'd1;
                end
            end

            // lock_req wins over submit; a rejected code neither reloads nor runs the timer.
            UNLOCKED: begin
                if (lock_req) begin
                    state_next = LOCKED;
                end else if (submit) begin
                    if (!set_mode) begin
                        clear_d      = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = UNLOCK_LOAD;
                    end else if (all_keys_valid(typed)) begin
                        code_next    = typed;
                        saved_d      = 1'b1;
                        clear_d      = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = UNLOCK_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (UNLOCK_TIMEOUT != 0) begin
                    tmr_en = 1'b1;
                    if (tmr_one || tmr_zero) begin
                        state_next = LOCKED;
                    end
                end
            end

            LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_one || tmr_zero) begin
                    state_next = LOCKED;
                    fail_next  = '0;
                end
            end

            default: state_next = LOCKED;
        endcase
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            unlocked      <= 1'b0;
            alarm         <= 1'b0;
            clear_list    <= 1'b0;
            code_saved    <= 1'b0;
            code_err      <= 1'b0;
            attempts_left <= MAX_FAIL;
        end else begin
            unlocked      <= (state == UNLOCKED);
            alarm         <= (state == LOCKOUT);
            clear_list    <= clear_d;
            code_saved    <= saved_d;
            code_err      <= err_d;
            attempts_left <= MAX_FAIL - fail_cnt;
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller: table of per-cycle vectors plus
// hand-written sequences, all compared through an expected-output scoreboard.
module tb_lock_controller;

    localparam int LOCKOUT = 8;
    localparam int TIMEOUT = 10;

    logic        hwclk = 1'b0;
    logic        rst_n;
    logic [31:0] typed;
    logic        submit, set_mode, lock_req;
    logic        unlocked, alarm, clear_list, code_saved, code_err;
    logic [3:0]  attempts_left;

    typedef struct packed {
        logic       unlocked;
        logic       alarm;
        logic       clear_list;
        logic       code_saved;
        logic       code_err;
        logic [3:0] attempts_left;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] typed;
        logic        submit;
        logic        set_mode;
        logic        lock_req;
        outs_t       exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t sb_exp[$];
    string sb_name[$];
    int    compared   = 0;
    int    mismatched = 0;

    always #5 hwclk = ~hwclk;

    lock_controller #(
        .DEFAULT_CODE   (32'h01020304),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (LOCKOUT),
        .UNLOCK_TIMEOUT (TIMEOUT)
    ) dut (
        .hwclk         (hwclk),
        .rst_n         (rst_n),
        .typed         (typed),
        .submit        (submit),
        .set_mode      (set_mode),
        .lock_req      (lock_req),
        .unlocked      (unlocked),
        .alarm         (alarm),
        .clear_list    (clear_list),
        .code_saved    (code_saved),
        .code_err      (code_err),
        .attempts_left (attempts_left)
    );

    function automatic outs_t o(input logic u, input logic a, input logic cl,
                                input logic sv, input logic er, input logic [3:0] att);
        outs_t r;
        r.unlocked      = u;
        r.alarm         = a;
        r.clear_list    = cl;
        r.code_saved    = sv;
        r.code_err      = er;
        r.attempts_left = att;
        return r;
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] t, input logic s,
                                input logic sm, input logic lr, input outs_t e);
        vec_t v;
        v.name     = n;
        v.typed    = t;
        v.submit   = s;
        v.set_mode = sm;
        v.lock_req = lr;
        v.exp      = e;
        return v;
    endfunction

    function automatic outs_t actual();
        return o(unlocked, alarm, clear_list, code_saved, code_err, attempts_left);
    endfunction

    task automatic report(input string n, input outs_t act, input outs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got u=%b a=%b cl=%b sv=%b er=%b att=%0d, expected u=%b a=%b cl=%b sv=%b er=%b att=%0d",
                     n, act.unlocked, act.alarm, act.clear_list, act.code_saved, act.code_err, act.attempts_left,
                     exp.unlocked, exp.alarm, exp.clear_list, exp.code_saved, exp.code_err, exp.attempts_left);
        end
    endtask

    // Drives one cycle of inputs and records what the outputs must be after the sampling edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge hwclk);
        typed    = v.typed;
        submit   = v.submit;
        set_mode = v.set_mode;
        lock_req = v.lock_req;
        sb_exp.push_back(v.exp);
        sb_name.push_back(v.name);
        @(posedge hwclk);
        #1;
    endtask

    task automatic checkOutput();
        outs_t exp;
        string n;
        if (sb_exp.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: output observed with no expectation queued");
        end else begin
            exp = sb_exp.pop_front();
            n   = sb_name.pop_front();
            report(n, actual(), exp);
        end
    endtask

    task automatic run(input string n, input logic [31:0] t, input logic s,
                       input logic sm, input logic lr, input outs_t e);
        applyStimulus(mk(n, t, s, sm, lr, e));
        checkOutput();
    endtask

    initial begin
        rst_n    = 1'b0;
        typed    = '0;
        submit   = 1'b0;
        set_mode = 1'b0;
        lock_req = 1'b0;

        // Basic unlock, wrong attempts and the full lockout window.
        vecs.push_back(mk("submit_ok",    32'h01020304, 1, 0, 0, o(0,0,0,0,0,3)));
        vecs.push_back(mk("check_ok",     32'h0,        0, 0, 0, o(0,0,1,0,0,3)));
        vecs.push_back(mk("unlocked",     32'h0,        0, 0, 0, o(1,0,0,0,0,3)));
        vecs.push_back(mk("lock_req",     32'h0,        0, 0, 1, o(1,0,0,0,0,3)));
        vecs.push_back(mk("wrong1",       32'h01020305, 1, 0, 0, o(0,0,0,0,0,3)));
        vecs.push_back(mk("wrong1_chk",   32'h0,        0, 0, 0, o(0,0,1,0,0,3)));
        vecs.push_back(mk("wrong2",       32'h01020305, 1, 0, 0, o(0,0,0,0,0,2)));
        vecs.push_back(mk("wrong2_chk",   32'h0,        0, 0, 0, o(0,0,1,0,0,2)));
        vecs.push_back(mk("after_two",    32'h0,        0, 0, 0, o(0,0,0,0,0,1)));
        vecs.push_back(mk("wrong3",       32'h01020305, 1, 0, 0, o(0,0,0,0,0,1)));
        vecs.push_back(mk("wrong3_chk",   32'h0,        0, 0, 0, o(0,0,1,0,0,1)));
        for (int i = 0; i < LOCKOUT; i++) begin
            vecs.push_back(mk($sformatf("lockout_%0d", i),
                              (i == 2) ? 32'h01020304 : 32'h0,
                              (i == 2), 1'b0, (i == 5), o(0,1,0,0,0,0)));
        end
        vecs.push_back(mk("lockout_end",  32'h0,        0, 0, 0, o(0,0,0,0,0,3)));
        vecs.push_back(mk("post_lockout", 32'h0,        0, 0, 0, o(0,0,0,0,0,3)));

        repeat (2) @(posedge hwclk);
        #1;
        report("reset_state", actual(), o(0,0,0,0,0,3));
        @(negedge hwclk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Programming a new code, then proving old code fails and new code works.
        run("prg_submit",     32'h01020304, 1, 0, 0, o(0,0,0,0,0,3));
        run("prg_check",      32'h0,        0, 0, 0, o(0,0,1,0,0,3));
        run("prg_save",       32'h05060708, 1, 1, 0, o(1,0,1,1,0,3));
        run("prg_after_save", 32'h0,        0, 0, 0, o(1,0,0,0,0,3));
        run("prg_lock",       32'h0,        0, 0, 1, o(1,0,0,0,0,3));
        run("old_code",       32'h01020304, 1, 0, 0, o(0,0,0,0,0,3));
        run("old_code_chk",   32'h0,        0, 0, 0, o(0,0,1,0,0,3));
        run("new_code",       32'h05060708, 1, 0, 0, o(0,0,0,0,0,2));
        run("new_code_chk",   32'h0,        0, 0, 0, o(0,0,1,0,0,2));
        run("new_unlocked",   32'h0,        0, 0, 0, o(1,0,0,0,0,3));
        run("plain_submit",   32'h01020304, 1, 0, 0, o(1,0,1,0,0,3));
        run("bad_code",       32'h00050607, 1, 1, 0, o(1,0,0,0,1,3));
        run("lock_vs_save",   32'h0a0b0c0d, 1, 1, 1, o(1,0,0,0,0,3));
        run("relocked",       32'h0,        0, 0, 0, o(0,0,0,0,0,3));
        run("kept_code",      32'h05060708, 1, 0, 0, o(0,0,0,0,0,3));
        run("kept_code_chk",  32'h0,        0, 0, 0, o(0,0,1,0,0,3));

        // Idle in UNLOCKED until the auto-relock timer expires.
        for (int i = 0; i < TIMEOUT; i++) begin
            run($sformatf("idle_unlocked_%0d", i), 32'h0, 0, 0, 0, o(1,0,0,0,0,3));
        end
        run("timeout_relock", 32'h0, 0, 0, 0, o(0,0,0,0,0,3));

        // Drive into LOCKOUT with the programmed code active, then reset mid-lockout.
        run("rl_wrong1",     32'h01020304, 1, 0, 0, o(0,0,0,0,0,3));
        run("rl_wrong1_chk", 32'h0,        0, 0, 0, o(0,0,1,0,0,3));
        run("rl_wrong2",     32'h01020304, 1, 0, 0, o(0,0,0,0,0,2));
        run("rl_wrong2_chk", 32'h0,        0, 0, 0, o(0,0,1,0,0,2));
        run("rl_wrong3",     32'h01020304, 1, 0, 0, o(0,0,0,0,0,1));
        run("rl_wrong3_chk", 32'h0,        0, 0, 0, o(0,0,1,0,0,1));
        run("rl_lockout0",   32'h0,        0, 0, 0, o(0,1,0,0,0,0));
        run("rl_lockout1",   32'h0,        0, 0, 0, o(0,1,0,0,0,0));

        @(negedge hwclk);
        #2;
        rst_n = 1'b0;
        #1;
        report("async_reset", actual(), o(0,0,0,0,0,3));
        @(negedge hwclk);
        rst_n = 1'b1;

        run("default_submit", 32'h01020304, 1, 0, 0, o(0,0,0,0,0,3));
        run("default_check",  32'h0,        0, 0, 0, o(0,0,1,0,0,3));
        run("default_unlock", 32'h0,        0, 0, 0, o(1,0,0,0,0,3));

        if (sb_exp.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb_exp.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
